// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the soft CPU pipeline.
//   WB_SEL_*  : writeback source select codes (11 aliases ALU)
//   F3_*      : load funct3 size/sign codes
//   REG_X0    : hardwired-zero register index
package cpu_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load-data extraction and extension.
//   rdata_i   : raw aligned memory word
//   addr_lo_i : low address bits (byte lane; bit 1 selects half)
//   funct3_i  : load size/sign code
//   data_o    : extended XLEN-wide load value
// Shared with the debug memory port.
module load_extend
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] byte_sh, half_sh;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  // Lane selection by shifting keeps this generic in XLEN; half ignores addr bit 0.
  assign byte_sh = rdata_i >> {addr_lo_i, 3'b000};
  assign half_sh = rdata_i >> {addr_lo_i[1], 4'b0000};
  assign byte_v  = byte_sh[7:0];
  assign half_v  = half_sh[15:0];

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register of the soft CPU.
//   Clock/Reset            : rising-edge clock, synchronous active-low reset
//   ClockEnable, Tick      : state advances only when both are high
//   stall / flush          : hold WB contents / insert a bubble (flush wins)
//   mem_*                  : MEM-stage instruction bundle
//   wb_valid/we/rd/data    : registered writeback bundle (we never set for x0)
//   wb_pc_plus4            : registered PC+4
//   halted                 : sticky after a valid halt instruction retires
//   retired_count          : saturating count of retired instructions
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ClockEnable,
  input  logic             Tick,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [2:0]       mem_funct3,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [1:0]       mem_wb_sel,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic             mem_halt,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  wb_pc_plus4,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  logic             adv;
  logic [XLEN-1:0]  ld_data, sel_data;

  logic             valid_q, valid_d;
  logic             rw_q, rw_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign adv = ClockEnable & Tick;

  load_extend #(.XLEN(XLEN)) u_ld (
    .rdata_i   (mem_rdata),
    .addr_lo_i (mem_alu_result[1:0]),
    .funct3_i  (mem_funct3),
    .data_o    (ld_data)
  );

  always_comb begin
    case (mem_wb_sel)
      WB_SEL_LOAD: sel_data = ld_data;
      WB_SEL_PC4:  sel_data = mem_pc_plus4;
      default:     sel_data = mem_alu_result;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    rd_d    = rd_q;
    data_d  = data_q;
    pc4_d   = pc4_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    if (adv) begin
      if (flush || (!stall && halt_q)) begin
        // Bubble: only the control bits drop, data fields hold.
        valid_d = 1'b0;
        rw_d    = 1'b0;
      end else if (!stall) begin
        valid_d = mem_valid;
        rw_d    = mem_reg_write;
        rd_d    = mem_rd;
        data_d  = sel_data;
        pc4_d   = mem_pc_plus4;
        if (mem_valid) begin
          if (mem_halt)      halt_d = 1'b1;
          if (cnt_q != '1)   cnt_d  = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      pc4_q   <= '0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      pc4_q   <= pc4_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_valid      = valid_q;
  assign wb_we         = valid_q & rw_q & (rd_q != REG_X0);
  assign wb_rd         = rd_q;
  assign wb_data       = data_q;
  assign wb_pc_plus4   = pc4_q;
  assign halted        = halt_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        Clock = 1'b0;
  logic        Reset, ClockEnable, Tick, stall, flush;
  logic        mem_valid, mem_reg_write, mem_halt;
  logic [31:0] mem_alu_result, mem_rdata, mem_pc_plus4;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;

  logic        wb_valid, wb_we, halted;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_pc_plus4, retired_count;

  logic        s_valid, s_we, s_halted;
  logic [4:0]  s_rd;
  logic [31:0] s_data, s_pc4;
  logic [3:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  mem_wb_stage dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_wb_sel(mem_wb_sel), .mem_pc_plus4(mem_pc_plus4), .mem_halt(mem_halt),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc_plus4(wb_pc_plus4), .halted(halted), .retired_count(retired_count)
  );

  // Narrow-counter instance for saturation; shares all inputs.
  mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut_sat (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_wb_sel(mem_wb_sel), .mem_pc_plus4(mem_pc_plus4), .mem_halt(mem_halt),
    .wb_valid(s_valid), .wb_we(s_we), .wb_rd(s_rd), .wb_data(s_data),
    .wb_pc_plus4(s_pc4), .halted(s_halted), .retired_count(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] alu, input logic [31:0] rd_data,
                     input logic [2:0] f3, input logic [4:0] rd, input logic rw,
                     input logic [1:0] sel, input logic [31:0] pc4, input logic hlt);
    mem_valid = v; mem_alu_result = alu; mem_rdata = rd_data; mem_funct3 = f3;
    mem_rd = rd; mem_reg_write = rw; mem_wb_sel = sel; mem_pc_plus4 = pc4; mem_halt = hlt;
  endtask

  initial begin
    Reset = 1'b0; ClockEnable = 1'b1; Tick = 1'b1; stall = 1'b0; flush = 1'b0;
    drv(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 2'b00, 32'h0, 1'b0);
    cyc(); cyc();
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_we",    {31'd0, wb_we}, 32'd0);
    chk("rst_rd",    {27'd0, wb_rd}, 32'd0);
    chk("rst_data",  wb_data, 32'd0);
    chk("rst_pc4",   wb_pc_plus4, 32'd0);
    chk("rst_halt",  {31'd0, halted}, 32'd0);
    chk("rst_cnt",   retired_count, 32'd0);
    Reset = 1'b1;

    // Load extraction
    drv(1'b1, 32'd3, 32'h80FF7F01, 3'b000, 5'd5, 1'b1, 2'b01, 32'h4, 1'b0); cyc();
    chk("lb_data",  wb_data, 32'hFFFFFF80);
    chk("lb_we",    {31'd0, wb_we}, 32'd1);
    chk("lb_rd",    {27'd0, wb_rd}, 32'd5);
    chk("lb_cnt",   retired_count, 32'd1);
    drv(1'b1, 32'd2, 32'h8001ABCD, 3'b101, 5'd5, 1'b1, 2'b01, 32'h8, 1'b0); cyc();
    chk("lhu_data", wb_data, 32'h00008001);
    mem_funct3 = 3'b001; cyc();
    chk("lh_data",  wb_data, 32'hFFFF8001);
    mem_funct3 = 3'b011; cyc();
    chk("f3_011",   wb_data, 32'h8001ABCD);
    mem_funct3 = 3'b100; mem_alu_result = 32'd1; cyc();
    chk("lbu_data", wb_data, 32'h000000AB);
    mem_funct3 = 3'b001; mem_alu_result = 32'd3; cyc();
    chk("lh_odd",   wb_data, 32'hFFFF8001);
    chk("cnt6",     retired_count, 32'd6);

    // PC+4 select into x0
    drv(1'b1, 32'h0, 32'h0, 3'b010, 5'd0, 1'b1, 2'b10, 32'h104, 1'b0); cyc();
    chk("pc4_data",  wb_data, 32'h104);
    chk("pc4_valid", {31'd0, wb_valid}, 32'd1);
    chk("x0_we",     {31'd0, wb_we}, 32'd0);
    chk("pc4_reg",   wb_pc_plus4, 32'h104);

    // Stall
    drv(1'b1, 32'h1234, 32'h0, 3'b010, 5'd3, 1'b1, 2'b00, 32'h200, 1'b0); cyc();
    chk("pre_stall", wb_data, 32'h1234);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 32'hA0 + i, 32'h0, 3'b010, 5'(10 + i), 1'b1, 2'b00, 32'h300, 1'b0); cyc();
      chk("stall_data", wb_data, 32'h1234);
      chk("stall_rd",   {27'd0, wb_rd}, 32'd3);
      chk("stall_pc4",  wb_pc_plus4, 32'h200);
    end
    chk("stall_cnt", retired_count, 32'd8);
    flush = 1'b1; cyc();
    chk("sf_valid", {31'd0, wb_valid}, 32'd0);
    chk("sf_we",    {31'd0, wb_we}, 32'd0);
    chk("sf_cnt",   retired_count, 32'd8);
    stall = 1'b0; flush = 1'b0;
    drv(1'b1, 32'h55, 32'h0, 3'b010, 5'd4, 1'b1, 2'b00, 32'h400, 1'b0); cyc();
    chk("post_data", wb_data, 32'h55);
    chk("post_cnt",  retired_count, 32'd9);

    // Gating
    ClockEnable = 1'b0; mem_alu_result = 32'h66; cyc();
    chk("ce_data", wb_data, 32'h55);
    chk("ce_cnt",  retired_count, 32'd9);
    ClockEnable = 1'b1; Tick = 1'b0; cyc();
    chk("tk_data", wb_data, 32'h55);
    chk("tk_cnt",  retired_count, 32'd9);
    Tick = 1'b1;

    // Halt
    drv(1'b1, 32'd7, 32'h0, 3'b010, 5'd6, 1'b1, 2'b00, 32'h500, 1'b1); cyc();
    chk("h_halt", {31'd0, halted}, 32'd1);
    chk("h_data", wb_data, 32'd7);
    chk("h_we",   {31'd0, wb_we}, 32'd1);
    chk("h_cnt",  retired_count, 32'd10);
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'h99, 32'h0, 3'b010, 5'd7, 1'b1, 2'b00, 32'h600, 1'b0); cyc();
      chk("ah_valid", {31'd0, wb_valid}, 32'd0);
      chk("ah_cnt",   retired_count, 32'd10);
    end
    Reset = 1'b0; cyc();
    chk("hr_halt",  {31'd0, halted}, 32'd0);
    chk("hr_cnt",   retired_count, 32'd0);
    chk("hr_valid", {31'd0, wb_valid}, 32'd0);
    Reset = 1'b1;
    drv(1'b1, 32'h42, 32'h0, 3'b010, 5'd2, 1'b1, 2'b00, 32'h700, 1'b0); cyc();
    chk("pr_valid", {31'd0, wb_valid}, 32'd1);
    chk("pr_data",  wb_data, 32'h42);
    chk("pr_cnt",   retired_count, 32'd1);

    // Saturation on the 4-bit counter
    Reset = 1'b0; cyc(); Reset = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      drv(1'b1, 32'(i), 32'h0, 3'b010, 5'd1, 1'b1, 2'b00, 32'h0, 1'b0); cyc();
      chk("sat_cnt", {28'd0, s_cnt}, (i > 15) ? 32'd15 : 32'(i));
    end
    chk("wide_cnt", retired_count, 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
